// File: rtl/nibble_packer_pkg.sv
// Shared types and constants for the nibble packer: FSM encoding, widths, FIFO entry layout.
package nibble_pkg;

  localparam int NIBBLE_W = 4;
  localparam int BYTE_W   = 8;
  localparam logic [NIBBLE_W-1:0] PAD_NIBBLE = 4'h0;

  typedef enum logic {
    S_LOW  = 1'b0,
    S_HIGH = 1'b1
  } state_t;

  // FIFO entry is {pad, byte}; pad marks a flushed half byte.
  typedef struct packed {
    logic              pad;
    logic [BYTE_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/nibble_packer_if.sv
// Nibble-in / byte-out handshake bundle; master drives nibbles and byte_ready_i, slave is the packer.
interface nibble_packer_if #(parameter int DEPTH = 4);
  import nibble_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic                valid_i;
  logic [NIBBLE_W-1:0] data_i;
  logic                ready_o;
  logic                flush_i;
  logic                byte_valid_o;
  logic [BYTE_W-1:0]   byte_o;
  logic                byte_pad_o;
  logic                byte_ready_i;
  logic [AW:0]         count_o;

  modport master (
    output valid_i, data_i, flush_i, byte_ready_i,
    input  ready_o, byte_valid_o, byte_o, byte_pad_o, count_o
  );

  modport slave (
    input  valid_i, data_i, flush_i, byte_ready_i,
    output ready_o, byte_valid_o, byte_o, byte_pad_o, count_o
  );

endinterface

// File: rtl/nibble_packer_sync_fifo.sv
// Single-clock FIFO with unregistered head read; push/pop in one cycle keeps count.
// Caller must never push when full nor pop when empty.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];
  assign full      = (count == CNT_FULL);
  assign empty     = (count == '0);

endmodule

// File: rtl/nibble_packer.sv
// Packs nibble pairs (first nibble low) into bytes through a small FIFO; flush emits a padded half byte.
// Byte visible the cycle after the second nibble; ready_o depends only on state and registered count.
module nibble_packer import nibble_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  nibble_packer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  state_t              state;
  state_t              state_nxt;
  logic [NIBBLE_W-1:0] hold;
  logic                ready;
  logic                push;
  logic                pop;
  entry_t              push_entry;
  entry_t              head_entry;
  logic [AW:0]         count;
  logic                full;
  logic                empty;

  always_ff @(posedge clk) begin
    if (rst) state <= S_LOW;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOW:  if (bus.valid_i) state_nxt = S_HIGH;
      S_HIGH: if (!full && (bus.valid_i || bus.flush_i)) state_nxt = S_LOW;
      default: state_nxt = S_LOW;
    endcase
  end

  // A nibble handshake outranks flush; both are blocked while the FIFO is full.
  always_comb begin
    ready      = 1'b1;
    push       = 1'b0;
    push_entry = '0;
    if (state == S_HIGH) begin
      ready = !full;
      if (bus.valid_i && !full) begin
        push       = 1'b1;
        push_entry = '{pad: 1'b0, data: {bus.data_i, hold}};
      end else if (bus.flush_i && !full) begin
        push       = 1'b1;
        push_entry = '{pad: 1'b1, data: {PAD_NIBBLE, hold}};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) hold <= '0;
    else if (state == S_LOW && bus.valid_i) hold <= bus.data_i;
  end

  assign pop = !empty && bus.byte_ready_i;

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign bus.ready_o      = ready;
  assign bus.byte_valid_o = !empty;
  assign bus.byte_o       = head_entry.data;
  assign bus.byte_pad_o   = head_entry.pad;
  assign bus.count_o      = count;

endmodule

// File: tb/tb_nibble_packer.sv
// Directed and random stimulus against a queue-based model of the nibble packer.
module tb_nibble_packer;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nibble_packer_if #(.DEPTH(DEPTH)) bus ();

  nibble_packer #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Model: at most one pending low nibble plus an ordered list of {pad, byte}.
  bit         held     = 1'b0;
  logic [3:0] held_nib = 4'h0;
  logic [8:0] q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs mid-cycle, advance the model, then step past the edge.
  task automatic tick();
    bit         exp_rdy;
    bit         acc;
    bit         pop;
    bit         do_push;
    logic [8:0] nb;
    @(negedge clk);
    exp_rdy = !held || (q.size() < DEPTH);
    check("ready_o", bus.ready_o, exp_rdy);
    check("byte_valid_o", bus.byte_valid_o, q.size() != 0);
    check("count_o", bus.count_o, q.size());
    if (q.size() != 0) begin
      check("byte_o", bus.byte_o, q[0][7:0]);
      check("byte_pad_o", bus.byte_pad_o, q[0][8]);
    end
    if (rst) begin
      q.delete();
      held = 1'b0;
    end else begin
      acc     = bus.valid_i && exp_rdy;
      pop     = (q.size() != 0) && bus.byte_ready_i;
      do_push = 1'b0;
      nb      = '0;
      if (!held) begin
        if (acc) begin
          held_nib = bus.data_i;
          held     = 1'b1;
        end
      end else if (acc) begin
        nb = {1'b0, bus.data_i, held_nib};
        do_push = 1'b1;
      end else if (bus.flush_i && q.size() < DEPTH) begin
        nb = {1'b1, 4'h0, held_nib};
        do_push = 1'b1;
      end
      if (do_push) held = 1'b0;
      if (pop) void'(q.pop_front());
      if (do_push) q.push_back(nb);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [3:0] d, input bit f, input bit br);
    bus.valid_i      = v;
    bus.data_i       = d;
    bus.flush_i      = f;
    bus.byte_ready_i = br;
  endtask

  task automatic drain();
    drive(1'b0, 4'h0, 1'b0, 1'b1);
    repeat (6) tick();
  endtask

  initial begin
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    tick();
    rst = 1'b0;
    check("rst_byte_o", bus.byte_o, 8'h00);
    check("rst_pad", bus.byte_pad_o, 1'b0);
    check("rst_ready", bus.ready_o, 1'b1);

    // 1: back-to-back pair, immediate pop
    drive(1'b1, 4'h1, 1'b0, 1'b1); tick();
    drive(1'b1, 4'h2, 1'b0, 1'b1); tick();
    drive(1'b0, 4'h0, 1'b0, 1'b1);
    check("t1_valid", bus.byte_valid_o, 1'b1);
    check("t1_byte", bus.byte_o, 8'h21);
    tick();
    check("t1_count", bus.count_o, 0);

    // 2: fill to full, stall, drain in order
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 4'(i), 1'b0, 1'b0);
      tick();
    end
    check("t2_count_full", bus.count_o, DEPTH);
    check("t2_ready_stall", bus.ready_o, 1'b0);
    check("t2_head", bus.byte_o, 8'h10);
    drive(1'b1, 4'h9, 1'b0, 1'b1); tick(); tick();
    drain();
    drive(1'b0, 4'h0, 1'b0, 1'b0);

    // 3: simultaneous push and pop at count 2, then wrap
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'(i + 3), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 4'hE, 1'b0, 1'b1); tick();
    check("t3_count_same", bus.count_o, 2);
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 4'(i), 1'b0, 1'b1);
      tick();
    end
    drain();

    // 4: flush a half byte, then flush with nothing held
    drive(1'b1, 4'hA, 1'b0, 1'b0); tick();
    drive(1'b0, 4'h0, 1'b1, 1'b0); tick();
    check("t4_byte", bus.byte_o, 8'h0A);
    check("t4_pad", bus.byte_pad_o, 1'b1);
    tick();
    check("t4_flush_idle", bus.count_o, 1);
    drain();

    // 5: nibble beats flush; flush held across full
    drive(1'b1, 4'h3, 1'b0, 1'b0); tick();
    drive(1'b1, 4'hC, 1'b1, 1'b0); tick();
    drive(1'b0, 4'h0, 1'b0, 1'b0); tick();
    check("t5_one_byte", bus.count_o, 1);
    check("t5_byte", bus.byte_o, 8'hC3);
    check("t5_pad", bus.byte_pad_o, 1'b0);
    drain();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 4'(15 - i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 4'h0, 1'b1, 1'b0); tick(); tick();
    drive(1'b0, 4'h0, 1'b1, 1'b1); tick();
    drive(1'b0, 4'h0, 1'b1, 1'b0); tick();
    check("t5_full_flush", bus.count_o, DEPTH);
    drain();

    // 6: reset mid-operation
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 4'(i + 8), 1'b0, 1'b0);
      tick();
    end
    rst = 1'b1;
    drive(1'b0, 4'h0, 1'b0, 1'b0); tick();
    rst = 1'b0;
    check("t6_valid", bus.byte_valid_o, 1'b0);
    check("t6_count", bus.count_o, 0);
    check("t6_ready", bus.ready_o, 1'b1);
    drive(1'b1, 4'h5, 1'b0, 1'b0); tick();
    drive(1'b1, 4'h6, 1'b0, 1'b0); tick();
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    check("t6_byte", bus.byte_o, 8'h65);
    drain();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 2) == 0));
      tick();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
